// File: rtl/gray_decoder.sv
// Two-stage Gray-to-binary decoder with step tracking against the previous sample.
// Flags up/down steps, holds and illegal jumps; keeps a saturating error count.
//
//   state  | meaning
//   EMPTY  | no reference value yet; next sample reports first
//   LOCKED | prev holds last decoded value; next sample is compared
module gray_decoder #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             first,
    output logic             step_up,
    output logic             step_dn,
    output logic             hold,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {EMPTY = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] g_q;
    logic             v1;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;
    logic             f_first, f_up, f_dn, f_hold, f_err;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        f_first   = 1'b0;
        f_up      = 1'b0;
        f_dn      = 1'b0;
        f_hold    = 1'b0;
        f_err     = 1'b0;
        b         = gray2bin(g_q);
        prev_inc  = prev + ONE;
        prev_dec  = prev - ONE;
        if (v1) begin
            case (state)
                EMPTY: begin
                    f_first   = 1'b1;
                    state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (b == prev_inc) begin
                        f_up = 1'b1;
                    end else if (b == prev_dec) begin
                        f_dn = 1'b1;
                    end else if (b == prev) begin
                        f_hold = 1'b1;
                    end else begin
                        f_err = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            g_q       <= '0;
            v1        <= 1'b0;
            prev      <= '0;
            bin_out   <= '0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            hold      <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            // bin_out deliberately keeps its last value across a flush
            v1        <= 1'b0;
            prev      <= '0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            hold      <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                g_q <= gray_in;
            end
            out_valid <= v1;
            first     <= f_first;
            step_up   <= f_up;
            step_dn   <= f_dn;
            hold      <= f_hold;
            err_pulse <= f_err;
            if (v1) begin
                bin_out <= b;
                prev    <= b;
            end
            if (f_err && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Pipelined Gray-to-binary decoder and step checker. It is the receive end for Gray-coded counts produced by the team's Gray counters, for example a count carried across a clock boundary or off-chip. Each valid Gray sample is converted to binary and compared against the previous decoded value. The block flags up steps, down steps, holds and illegal jumps, and keeps a saturating error count.

## Interface
- `WIDTH`, 8: Gray/binary word width, ≥ 2.
- `ERR_W`, 8: error counter width.

- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-low; clock `clk`.
- `gray_in`  in  WIDTH: Gray-coded sample.
- `in_valid`  in  1: `gray_in` valid this cycle.
- `clear`  in  1: synchronous active-high flush; returns tracker to EMPTY and zeroes `err_count`.
- `bin_out`  out  WIDTH: decoded binary value.
- `out_valid`  out  1: one-cycle pulse; `bin_out` and the flags below are valid.
- `first`  out  1: sample is the first one after reset or clear; no comparison was made.
- `step_up`  out  1: decoded value = previous + 1 mod 2^WIDTH.
- `step_dn`  out  1: decoded value = previous − 1 mod 2^WIDTH.
- `hold`  out  1: decoded value = previous.
- `err_pulse`  out  1: any other relationship, an illegal jump.
- `err_count`  out  ERR_W: saturating count of `err_pulse` events.

## Operation
- **Conversion:**
  - `b[WIDTH-1] = g[WIDTH-1]`.
  - `b[i] = b[i+1] ^ g[i]` for i = WIDTH-2 down to 0.
  - All arithmetic is mod 2^WIDTH.
- **Stage 1:** on `in_valid`, register `gray_in` into `g_q` and set `v1 = 1`. Otherwise `v1 = 0`.
- **Stage 2:** when `v1` = 1:
  - Compute `b` from `g_q`.
  - Drive `bin_out = b` and `out_valid = 1`.
  - Evaluate the flags against `prev`.
  - Then set `prev = b`.
- **Tracker FSM**, two states:
  - **EMPTY**, the reset state. On a stage-2 sample: `first = 1`, all other flags 0, load `prev`, go to LOCKED.
  - **LOCKED**. On a stage-2 sample, exactly one of `step_up`/`step_dn`/`hold`/`err_pulse` is 1, and `first = 0`.
    - `prev` is always updated to `b`, including on error, so the tracker resyncs to the new value.
    - LOCKED → EMPTY only on `clear` or `reset`.
- **Wrap-around:**
  - prev = 2^WIDTH−1, new = 0 → `step_up`.
  - prev = 0, new = 2^WIDTH−1 → `step_dn`.
- **Errors:** `err_count` increments on each `err_pulse` and saturates at 2^ERR_W−1 (no wrap).
- **Flags:** all flags and `out_valid` are 0 in cycles without a stage-2 sample. `bin_out` holds its last value.
- **clear:**
  - Drops `v1` and any sample accepted in the same cycle; `in_valid` coincident with `clear` is discarded.
  - Forces EMPTY, zeroes `err_count` and `prev`, and drives `out_valid` and all flags to 0 next cycle.
  - `bin_out` retains its value.
- **reset** (low): same as `clear`, and additionally `bin_out = 0`.
- **Reset values:** `bin_out` 0, `out_valid` 0, `first` 0, `step_up` 0, `step_dn` 0, `hold` 0, `err_pulse` 0, `err_count` 0, state EMPTY, `v1` 0.
- **reset vs clear:** `reset` has priority over `clear`; `clear` has priority over `in_valid`.

## Timing
- **Latency:** 2 clocks. A sample accepted at edge k (`in_valid` = 1 before k) produces `out_valid` and flags registered at edge k+1, visible in the cycle after k+1.
- **Throughput:** one sample per clock. Back-to-back `in_valid` is supported with no bubbles.
- **Outputs:** all outputs are registered; there is no combinational path from input to output.
- **Reset mid-stream:** a sample in stage 1 when `reset` is low is lost. The first sample after `reset` is released reports `first`.
- **Gaps:** `in_valid` gaps of any length do not affect tracking. Comparison is always against the last valid sample.

## Test plan
- **Reset and first sample:** reset low 3 cycles. Check all outputs 0. Then `gray_in` = 0x80 with `in_valid` for one cycle → 2 clocks later `bin_out` = 0xFF, `out_valid` = 1, `first` = 1, other flags 0.
- **Up wrap and continuous up count:** gray 0x80 then 0x00 → second output `bin_out` = 0x00 with `step_up` = 1. Then gray of 0..255 consecutively on back-to-back cycles → 255 `step_up` pulses, `err_count` = 0.
- **Down step and hold:** gray 0x02 (bin 3), 0x03 (bin 2), 0x03 → flags `first`, then `step_dn`, then `hold`. Then gray 0x00 (bin 0) → `err_pulse` (jump 2→0), `err_count` = 1.
- **Illegal jump and resync:** gray 0x07 (bin 5), 0x0D (bin 9), 0x0C (bin 8) → `first`, then `err_pulse` with `err_count` = 1, then `step_dn` (9→8). This confirms `prev` updated on error.
- **Saturation:** feed 260 alternating samples bin 0x00/0x80 (gray 0x00/0xC0) → 259 errors, `err_count` stops at 0xFF.
- **clear and reset mid-stream:**
  - Assert `clear` together with `in_valid` (gray 0x05) while a sample is in stage 1 → no `out_valid` for either sample, `err_count` = 0. The next sample reports `first`.
  - Repeat with `reset` low → additionally `bin_out` = 0.
